// File: rtl/hazard_stall_ctrl.sv
// Hazard, stall and flush controller for the five-stage MIPS pipeline.
// Produces pipeline-register write enables, flushes and EX forwarding selects.
// It also runs a memory-wait watchdog and keeps saturating performance counters.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_readmem,
  input  logic             ex_branch,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic              mem_timeout_q;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic memstall;
  logic lduse;

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Forwarding select for one EX source operand; MEM beats WB because it is younger.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src)) begin
      return 2'b10;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign memstall = mem_req & ~mem_ready;
  assign lduse    = ex_readmem & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  // Hazard priority: timeout freeze, memory stall, taken branch, load-use, jump.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (state_q == TIMEOUT) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (memstall) begin
      // A taken branch waiting in EX is held here and flushes on the release cycle.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lduse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Forwarding is evaluated every cycle; it is simply ignored while frozen.
  always_comb begin
    fwd_a = fwd_sel(ex_rs);
    fwd_b = fwd_sel(ex_rt);
  end

  // Next values of the performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if ((state_q != TIMEOUT) && (memstall || lduse)) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
    if (ifid_flush || idex_flush) begin
      flush_count_d = sat_inc(flush_count_q);
    end
  end

  // Memory-wait watchdog FSM; TIMEOUT is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (memstall) begin
            wait_cnt_q <= WCNT_W'(1);
            if (MEM_TIMEOUT <= 1) begin
              state_q       <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end else begin
              state_q <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (memstall) begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
            if ((wait_cnt_q + WCNT_W'(1)) >= TIMEOUT_VAL) begin
              state_q       <= TIMEOUT;
              mem_timeout_q <= 1'b1;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end
        end
        TIMEOUT: begin
          mem_timeout_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
module tb_hazard_stall_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic          id_uses_rt, id_jump, ex_readmem, ex_branch;
  logic          mem_regwrite, wb_regwrite, mem_req, mem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write;
  logic          ifid_flush, idex_flush, memwb_bubble;
  logic [1:0]    fwd_a, fwd_b;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  int consec;
  bit dead;
  int m_stall, m_flush;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_readmem(ex_readmem), .ex_branch(ex_branch),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt, id_jump;
    logic [4:0] ex_rs, ex_rt;
    logic       ex_readmem, ex_branch;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;
    logic       mem_req, mem_ready;
    logic [3:0] we;   // {pc, ifid, idex, exmem}
    logic [2:0] fl;   // {ifid_flush, idex_flush, memwb_bubble}
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_rs = 0; ex_rt = 0; ex_readmem = 0; ex_branch = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt; id_jump = v.id_jump;
    ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_readmem = v.ex_readmem; ex_branch = v.ex_branch;
    mem_rd = v.mem_rd; mem_regwrite = v.mem_regwrite;
    wb_rd = v.wb_rd; wb_regwrite = v.wb_regwrite;
    mem_req = v.mem_req; mem_ready = v.mem_ready;
  endtask

  // ---- reference model, straight from the hazard rules ----
  function automatic bit m_memstall();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit m_lduse();
    return ex_readmem && (ex_rt != 0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Which rule acts this cycle, as enables/flushes.
  function automatic logic [6:0] m_ctrl();
    if (dead)               return {4'b0000, 3'b001};
    else if (m_memstall())  return {4'b0000, 3'b001};
    else if (ex_branch)     return {4'b1111, 3'b110};
    else if (m_lduse())     return {4'b0011, 3'b010};
    else if (id_jump)       return {4'b1111, 3'b100};
    else                    return {4'b1111, 3'b000};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    consec = 0; dead = 0; m_stall = 0; m_flush = 0;
  endtask

  // Check all outputs against the model at the negative edge.
  task automatic settle();
    logic [6:0] c;
    @(negedge clk);
    c = m_ctrl();
    chk("model_we", 32'({pc_write, ifid_write, idex_write, exmem_write}), 32'(c[6:3]));
    chk("model_flush", 32'({ifid_flush, idex_flush, memwb_bubble}), 32'(c[2:0]));
    chk("model_fwd", 32'({fwd_a, fwd_b}), 32'({m_fwd(ex_rs), m_fwd(ex_rt)}));
    chk("model_timeout", 32'(mem_timeout), 32'(dead));
    chk("model_stall_cnt", 32'(stall_cycles), 32'(m_stall));
    chk("model_flush_cnt", 32'(flush_count), 32'(m_flush));
  endtask

  // Advance one rising edge and advance the model with the same inputs.
  task automatic tick();
    logic [6:0] c;
    @(posedge clk);
    c = m_ctrl();
    if (!dead && (m_memstall() || m_lduse()) && m_stall < CMAX) m_stall++;
    if ((c[2] || c[1]) && m_flush < CMAX) m_flush++;
    if (!dead) begin
      if (m_memstall()) begin
        consec++;
        if (consec >= TO) dead = 1;
      end else begin
        consec = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    chk("rst_we", 32'({pc_write, ifid_write, idex_write, exmem_write}), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero_inputs();
    rst_n = 1'b0;
    model_reset();

    tbl[0]  = '{we:4'hF, fl:3'b000, default:'0};
    tbl[1]  = '{ex_readmem:1, ex_rt:8, id_rs:8, we:4'b0011, fl:3'b010, default:'0};
    tbl[2]  = '{ex_readmem:1, we:4'hF, fl:3'b000, default:'0};
    tbl[3]  = '{ex_readmem:1, ex_rt:7, id_rt:7, id_uses_rt:1, id_rs:3,
                we:4'b0011, fl:3'b010, default:'0};
    tbl[4]  = '{ex_readmem:1, ex_rt:7, id_rt:7, id_rs:3, we:4'hF, fl:3'b000, default:'0};
    tbl[5]  = '{mem_rd:5, mem_regwrite:1, wb_rd:5, wb_regwrite:1, ex_rs:5, ex_rt:6,
                we:4'hF, fl:3'b000, fa:2'b10, fb:2'b00, default:'0};
    tbl[6]  = '{mem_rd:0, mem_regwrite:1, wb_rd:5, wb_regwrite:1, ex_rs:5,
                we:4'hF, fl:3'b000, fa:2'b01, default:'0};
    tbl[7]  = '{mem_rd:5, mem_regwrite:0, wb_rd:5, wb_regwrite:1, ex_rs:5, ex_rt:5,
                we:4'hF, fl:3'b000, fa:2'b01, fb:2'b01, default:'0};
    tbl[8]  = '{mem_rd:9, mem_regwrite:1, wb_rd:9, wb_regwrite:1, ex_rt:9,
                we:4'hF, fl:3'b000, fa:2'b00, fb:2'b10, default:'0};
    tbl[9]  = '{ex_branch:1, we:4'hF, fl:3'b110, default:'0};
    tbl[10] = '{id_jump:1, we:4'hF, fl:3'b100, default:'0};
    tbl[11] = '{ex_branch:1, ex_readmem:1, ex_rt:2, id_rs:2, we:4'hF, fl:3'b110, default:'0};
    tbl[12] = '{id_jump:1, ex_readmem:1, ex_rt:2, id_rs:2, we:4'b0011, fl:3'b010, default:'0};
    tbl[13] = '{mem_req:1, mem_ready:0, ex_branch:1, we:4'b0000, fl:3'b001, default:'0};
    tbl[14] = '{mem_req:1, mem_ready:1, we:4'hF, fl:3'b000, default:'0};
    tbl[15] = '{mem_req:1, mem_ready:0, we:4'b0000, fl:3'b001, default:'0};

    do_reset();

    // ---- vector table ----
    for (int i = 0; i < 16; i++) begin
      drive_vec(tbl[i]);
      settle();
      chk($sformatf("vec%0d_we", i), 32'({pc_write, ifid_write, idex_write, exmem_write}),
          32'(tbl[i].we));
      chk($sformatf("vec%0d_fl", i), 32'({ifid_flush, idex_flush, memwb_bubble}),
          32'(tbl[i].fl));
      chk($sformatf("vec%0d_fa", i), 32'(fwd_a), 32'(tbl[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(fwd_b), 32'(tbl[i].fb));
      tick();
    end

    // ---- load-use: one bubble, then forwarding from MEM ----
    do_reset();
    ex_readmem = 1; ex_rt = 8; id_rs = 8; id_rt = 8; id_uses_rt = 1;
    settle();
    chk("lduse_pc_write", 32'(pc_write), 32'd0);
    chk("lduse_ifid_write", 32'(ifid_write), 32'd0);
    chk("lduse_idex_flush", 32'(idex_flush), 32'd1);
    tick();
    zero_inputs();
    ex_rs = 8; ex_rt = 8; mem_rd = 8; mem_regwrite = 1;
    settle();
    chk("lduse_stall_cnt", 32'(stall_cycles), 32'd1);
    chk("lduse_fwd_a", 32'(fwd_a), 32'd2);
    chk("lduse_fwd_b", 32'(fwd_b), 32'd2);
    chk("lduse_after_pc", 32'(pc_write), 32'd1);
    tick();

    // ---- 3-cycle memory stall holding a taken branch ----
    do_reset();
    mem_req = 1; mem_ready = 0; ex_branch = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mstall_bubble", 32'(memwb_bubble), 32'd1);
      chk("mstall_pc", 32'(pc_write), 32'd0);
      chk("mstall_no_flush", 32'({ifid_flush, idex_flush}), 32'd0);
      tick();
    end
    mem_ready = 1;
    settle();
    chk("release_flush", 32'({ifid_flush, idex_flush}), 32'd3);
    chk("release_bubble", 32'(memwb_bubble), 32'd0);
    tick();
    zero_inputs();
    settle();
    chk("release_flush_cnt", 32'(flush_count), 32'd1);
    chk("release_stall_cnt", 32'(stall_cycles), 32'd3);
    tick();

    // ---- watchdog timeout ----
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      tick();
    end
    settle();
    chk("to_not_yet", 32'(mem_timeout), 32'd0);
    tick();
    settle();
    chk("to_set", 32'(mem_timeout), 32'd1);
    tick();
    mem_ready = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("to_frozen_pc", 32'(pc_write), 32'd0);
      chk("to_frozen_bubble", 32'(memwb_bubble), 32'd1);
      chk("to_sticky", 32'(mem_timeout), 32'd1);
      tick();
    end
    #2;
    do_reset();

    // ---- jump together with load-use ----
    ex_readmem = 1; ex_rt = 4; id_rs = 4; id_jump = 1;
    settle();
    chk("jmp_ld_ifid_write", 32'(ifid_write), 32'd0);
    chk("jmp_ld_ifid_flush", 32'(ifid_flush), 32'd0);
    tick();
    ex_readmem = 0; ex_rt = 0;
    settle();
    chk("jmp_after_flush", 32'(ifid_flush), 32'd1);
    tick();

    // ---- random stimulus against the model ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); id_jump = 1'($urandom_range(0, 3) == 0);
      ex_readmem = 1'($urandom); ex_branch = 1'($urandom_range(0, 3) == 0);
      mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
      mem_req = 1'($urandom); mem_ready = 1'($urandom_range(0, 3) != 0);
      settle();
      tick();
      if ((dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) do_reset();
    end

    // ---- counter saturation ----
    do_reset();
    ex_readmem = 1; ex_rt = 1; id_rs = 1;
    for (int i = 0; i < CMAX - 1; i++) tick();
    settle();
    chk("sat_pre_stall", 32'(stall_cycles), 32'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    settle();
    chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
    chk("sat_flush", 32'(flush_count), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
